sram_controller: RTL and testbench

- Memory-side responder that serves the MEM stage's data read/write requests from the board's external 16-bit SRAM.
- Each 32-bit word access is split into two sequential 16-bit SRAM accesses, low half first, then high half.
- `ready` is held low until the word access completes; the pipeline top uses `~ready` as a global freeze.

---
 rtl/sram_controller.sv | 119 +++++++++++
 tb/tb_sram_controller.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Word-wide MEM-stage port onto a 16-bit external SRAM: each word is two halfword accesses, low half first.
// Latency 2*ACCESS_CYCLES+1 cycles; ready stays low while busy and serves as the pipeline-wide freeze.
module sram_controller #(
  parameter int unsigned BASE_ADDR     = 1024,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        is_write_q, is_write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic [16:0] word_idx;
  logic        ready_c;

  // Out-of-window addresses simply wrap; only the 17-bit word index survives.
  assign word_idx = 17'((address - 32'(BASE_ADDR)) >> 2);

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      addr_q     <= '0;
      dq_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      dq_out_q   <= dq_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    dq_out_d   = dq_out_q;
    ready_c    = 1'b0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_dq_oe = 1'b0;

    case (state_q)
      IDLE: begin
        ready_c = ~(rd_en | wr_en);
        if (rd_en | wr_en) begin
          state_d    = LOW;
          cnt_d      = '0;
          is_write_d = wr_en;
          wdata_d    = write_data;
          addr_d     = {word_idx, 1'b0};
          if (wr_en) dq_out_d = write_data[15:0];
        end
      end
      LOW, HIGH: begin
        sram_we_n  = ~is_write_q;
        sram_oe_n  = is_write_q;
        sram_dq_oe = is_write_q;
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (state_q == LOW) begin
            state_d   = HIGH;
            addr_d[0] = 1'b1;
            if (is_write_q) dq_out_d = wdata_q[31:16];
            else            rdata_d[15:0] = sram_dq_in;
          end else begin
            state_d = DONE;
            if (!is_write_q) rdata_d[31:16] = sram_dq_in;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        ready_c = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The freeze must lift during reset even if the MEM stage is still requesting.
  assign ready       = ~rst | ready_c;
  assign read_data   = rdata_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_out_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller against a small behavioural SRAM model.
module tb_sram_controller;

  localparam int AC = 2;

  logic        CLOCK_50 = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  int checks = 0;
  int errors = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(AC)) dut (
    .CLOCK_50(CLOCK_50), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  logic [15:0] mem [0:255];
  always @(posedge CLOCK_50) if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq_out;
  assign sram_dq_in = mem[sram_addr[7:0]];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] exp_addr;
    logic        exp_wr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic run_vec(input vec_t v);
    rd_en = v.rd; wr_en = v.wr; address = v.addr; write_data = v.wdata;
    #1;
    chk("req_ready", 32'(ready), 32'd0);
    for (int c = 0; c < 2*AC; c++) begin
      @(negedge CLOCK_50);
      if (c == 0) begin
        address    = 32'h0000_0F00;
        write_data = ~v.wdata;
      end
      chk("busy_ready", 32'(ready), 32'd0);
      chk("sram_addr", 32'(sram_addr), 32'((c < AC) ? v.exp_addr : (v.exp_addr | 18'd1)));
      chk("we_n", 32'(sram_we_n), 32'(!v.exp_wr));
      chk("oe_n", 32'(sram_oe_n), 32'(v.exp_wr));
      chk("dq_oe", 32'(sram_dq_oe), 32'(v.exp_wr));
      if (v.exp_wr) chk("dq_out", 32'(sram_dq_out), 32'((c < AC) ? v.wdata[15:0] : v.wdata[31:16]));
    end
    @(negedge CLOCK_50);
    chk("done_ready", 32'(ready), 32'd1);
    chk("read_data", read_data, v.exp_rdata);
    rd_en = 1'b0; wr_en = 1'b0;
    @(negedge CLOCK_50);
    chk("idle_ready", 32'(ready), 32'd1);
    chk("idle_we_n", 32'(sram_we_n), 32'd1);
    chk("idle_oe_n", 32'(sram_oe_n), 32'd1);
  endtask

  initial begin
    int n;
    vec_t w;
    //             rd    wr    addr        wdata          exp_addr   wr    exp_rdata
    vecs[0] = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 18'h00002, 1'b1, 32'h00000000};
    vecs[1] = '{1'b1, 1'b0, 32'd1028, 32'h00000000, 18'h00002, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 32'd1032, 32'h12345678, 18'h00004, 1'b1, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b0, 32'd1032, 32'h00000000, 18'h00004, 1'b0, 32'h12345678};
    vecs[4] = '{1'b1, 1'b0, 32'd1031, 32'h00000000, 18'h00002, 1'b0, 32'hDEADBEEF};
    vecs[5] = '{1'b0, 1'b1, 32'd1020, 32'hA5A55A5A, 18'h3FFFE, 1'b1, 32'hDEADBEEF};
    vecs[6] = '{1'b1, 1'b0, 32'd1020, 32'h00000000, 18'h3FFFE, 1'b0, 32'hA5A55A5A};

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    rst = 1'b0; rd_en = 1'b1; wr_en = 1'b0; address = 32'd1024; write_data = '0;

    // Reset with a request held
    repeat (2) @(negedge CLOCK_50);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
    rst = 1'b1;
    #1;
    chk("post_rst_ready", 32'(ready), 32'd0);
    n = 0;
    while (ready !== 1'b1 && n < 20) begin @(negedge CLOCK_50); n++; end
    chk("first_latency", n, 32'd5);
    chk("first_read_data", read_data, 32'd0);
    rd_en = 1'b0;
    @(negedge CLOCK_50);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Back-to-back write then read, requests held across the boundary
    wr_en = 1'b1; address = 32'd1024; write_data = 32'h11112222;
    #1;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin @(negedge CLOCK_50); n++; end
    chk("b2b_wr_latency", n, 32'd5);
    wr_en = 1'b0; rd_en = 1'b1;
    @(negedge CLOCK_50);
    chk("b2b_idle_ready", 32'(ready), 32'd0);
    chk("b2b_idle_oe_n", 32'(sram_oe_n), 32'd1);
    @(negedge CLOCK_50);
    chk("b2b_low_oe_n", 32'(sram_oe_n), 32'd0);
    chk("b2b_low_addr", 32'(sram_addr), 32'd0);
    address = 32'd1028;
    n = 1;
    while (ready !== 1'b1 && n < 20) begin @(negedge CLOCK_50); n++; end
    chk("b2b_rd_latency", n, 32'd5);
    chk("b2b_read_data", read_data, 32'h11112222);
    rd_en = 1'b0;
    @(negedge CLOCK_50);

    // Reset during HIGH of a read
    rd_en = 1'b1; address = 32'd1028;
    repeat (3) @(negedge CLOCK_50);
    chk("abort_high_addr", 32'(sram_addr), 32'd3);
    chk("abort_high_oe_n", 32'(sram_oe_n), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_oe_n", 32'(sram_oe_n), 32'd1);
    chk("abort_we_n", 32'(sram_we_n), 32'd1);
    chk("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("abort_read_data", read_data, 32'd0);
    chk("abort_sram_addr", 32'(sram_addr), 32'd0);
    @(negedge CLOCK_50);
    rd_en = 1'b0;
    @(negedge CLOCK_50);
    rst = 1'b1;
    @(negedge CLOCK_50);

    // Window wrap: 1024 + 2^19 aliases word 0
    w = '{1'b1, 1'b0, 32'd1024 + 32'd524288, 32'h0, 18'h00000, 1'b0, 32'h11112222};
    run_vec(w);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
